uart_write_bram: RTL and testbench

Receive path counterpart to the BRAM-to-UART dump: accepts a stream of UART bytes (9600 baud, 8 data bits, even parity, 1 stop bit) and writes them to consecutive addresses of a single-port 8×2k block RAM, starting at address 0. It sits between the board UART RX pin and port A of the block RAM instance. It is used to load BRAM contents before a read-back dump.

---
 rtl/uart_write_bram_pkg.sv | 31 +++
 rtl/uart_write_bram_rx.sv | 109 ++++++++++
 rtl/uart_write_bram.sv | 124 ++++++++++++
 tb/tb_uart_write_bram.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_write_bram_pkg.sv
// Shared types and constants for the UART-to-BRAM loader.
// Holds writer/receiver state encodings, LED patterns and baud math.
package uart_write_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RECV  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } wr_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] LED_IDLE  = 8'b11000000;
    localparam logic [7:0] LED_RECV  = 8'b00110000;
    localparam logic [7:0] LED_WRITE = 8'b00001100;
    localparam logic [7:0] LED_DONE  = 8'b00000011;

    function automatic int bit_cyc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    localparam int DEF_BIT_CYC = bit_cyc(50_000_000, 9600);

endpackage

// File: rtl/uart_write_bram_rx.sv
// UART receiver: 8 data bits, even parity, 1 stop bit, LSB first.
// Ports: CLK_50M, rst_n, rx in; rx_data, rx_valid, perr, ferr out.
module uart_rx
    import uart_write_bram_pkg::*;
#(
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic       CLK_50M,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       perr,
    output logic       ferr
);

    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] FULL_LIM = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LIM = CW'(BIT_CYC / 2 - 1);

    rx_state_t     r_state;
    rx_state_t     w_next;
    logic [1:0]    r_sync;
    logic          r_rx_d;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_lim;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          w_rx_s;
    logic          w_fall;
    logic          w_tick;

    assign w_rx_s = r_sync[1];
    // r_rx_d trails the synchronized line by one cycle for edge detect
    assign w_fall = r_rx_d & ~w_rx_s;
    assign w_tick = (r_cnt == w_lim);

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_rx_d <= w_rx_s;
        end
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) r_state <= RX_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RX_IDLE:   if (w_fall) w_next = RX_START;
            RX_START:  if (w_tick) w_next = w_rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_tick && r_bit == 3'd7) w_next = RX_PARITY;
            RX_PARITY: if (w_tick) w_next = RX_STOP;
            RX_STOP:   if (w_tick) w_next = RX_IDLE;
            default:   w_next = RX_IDLE;
        endcase
    end

    // Start bit is checked at half a bit; later bits one full bit apart
    always_comb begin
        w_lim = FULL_LIM;
        if (r_state == RX_START) w_lim = HALF_LIM;
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (r_state == RX_IDLE) begin
                r_cnt <= '0;
                r_bit <= '0;
            end else if (w_tick) begin
                r_cnt <= '0;
                unique case (r_state)
                    RX_DATA: begin
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end
                    RX_PARITY: r_par <= w_rx_s;
                    RX_STOP: begin
                        rx_valid <= 1'b1;
                        rx_data  <= r_shift;
                        perr     <= ^{r_shift, r_par};
                        ferr     <= ~w_rx_s;
                    end
                    default: ;
                endcase
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_write_bram.sv
// Loads a stream of UART bytes into consecutive BRAM addresses from 0.
// Ports: CLK_50M, rst_n, start, rx in; bram_we/addr/din, busy, done,
// err_cnt, led out.
module uart_write_bram
    import uart_write_bram_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 2048,
    parameter int ADDR_W   = 12
) (
    input  logic              CLK_50M,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt,
    output logic [7:0]        led
);

    localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    wr_state_t         r_state;
    wr_state_t         w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_din;
    logic [7:0]        r_err;
    logic [7:0]        w_rx_data;
    logic              w_rx_valid;
    logic              w_perr;
    logic              w_ferr;
    logic              w_bad;

    uart_rx #(
        .BIT_CYC (BIT_CYC)
    ) u_rx (
        .CLK_50M  (CLK_50M),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (w_rx_data),
        .rx_valid (w_rx_valid),
        .perr     (w_perr),
        .ferr     (w_ferr)
    );

    assign w_bad     = w_perr | w_ferr;
    assign bram_addr = r_addr;
    assign bram_din  = r_din;
    assign err_cnt   = r_err;

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (start) w_next = ST_RECV;
            ST_RECV:  if (w_rx_valid && !w_bad) w_next = ST_WRITE;
            ST_WRITE: w_next = (r_addr == LAST) ? ST_DONE : ST_RECV;
            ST_DONE:  if (start) w_next = ST_RECV;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bram_we = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        led     = LED_IDLE;
        unique case (r_state)
            ST_IDLE:  led = LED_IDLE;
            ST_RECV: begin
                busy = 1'b1;
                led  = LED_RECV;
            end
            ST_WRITE: begin
                bram_we = 1'b1;
                busy    = 1'b1;
                led     = LED_WRITE;
            end
            ST_DONE: begin
                done = 1'b1;
                led  = LED_DONE;
            end
            default: led = LED_IDLE;
        endcase
    end

    // Address holds at LAST after the final write; no wrap
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_din  <= '0;
            r_err  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_addr <= '0;
                        r_err  <= '0;
                    end
                end
                ST_RECV: begin
                    if (w_rx_valid) begin
                        if (!w_bad)             r_din <= w_rx_data;
                        else if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                    end
                end
                ST_WRITE: begin
                    if (r_addr != LAST) r_addr <= r_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_write_bram.sv
// Directed bench for uart_write_bram with a short bit time and depth.
// Drives UART frames on rx and logs every bram_we write.
module tb_uart_write_bram;

    localparam int CLK_FREQ = 76800;
    localparam int BAUD     = 9600;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 12;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              rx;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_din;
    logic              busy;
    logic              done;
    logic [7:0]        err_cnt;
    logic [7:0]        led;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wa [0:63];
    logic [7:0]        wd [0:63];
    int                wn = 0;
    int                b;

    uart_write_bram #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .CLK_50M   (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx        (rx),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .led       (led)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bram_we) begin
            if (wn < 64) begin
                wa[wn] = bram_addr;
                wd[wn] = bram_din;
            end
            wn = wn + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        cyc(BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
        rx = 1'b1;
        cyc(4);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        start = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        rx    = 1'b1;
        cyc(3);
        check("rst_we", 32'(bram_we), 32'd0);
        check("rst_addr", 32'(bram_addr), 32'd0);
        check("rst_din", 32'(bram_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_led", 32'(led), 32'hC0);
        rst_n = 1'b1;
        cyc(3);

        // byte in IDLE is dropped
        b = wn;
        send_good(8'h11);
        check("idle_nwr", 32'(wn - b), 32'd0);
        check("idle_led", 32'(led), 32'hC0);
        check("idle_err", 32'(err_cnt), 32'd0);

        // full load, data = address
        pulse_start();
        check("ld_busy", 32'(busy), 32'd1);
        check("ld_led", 32'(led), 32'h30);
        b = wn;
        for (int i = 0; i < DEPTH; i++) send_good(8'(i));
        check("ld_nwr", 32'(wn - b), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check("ld_addr", 32'(wa[b+i]), 32'(i));
            check("ld_data", 32'(wd[b+i]), 32'(i));
        end
        check("ld_done", 32'(done), 32'd1);
        check("ld_busy0", 32'(busy), 32'd0);
        check("ld_led3", 32'(led), 32'h03);
        check("ld_err", 32'(err_cnt), 32'd0);
        check("ld_hold", 32'(bram_addr), 32'(DEPTH - 1));

        // extra byte in DONE is dropped
        b = wn;
        send_good(8'h99);
        check("done_nwr", 32'(wn - b), 32'd0);
        check("done_hold", 32'(bram_addr), 32'(DEPTH - 1));

        // restart from DONE
        pulse_start();
        check("rs_addr0", 32'(bram_addr), 32'd0);
        b = wn;
        send_good(8'h22);
        check("rs_nwr", 32'(wn - b), 32'd1);
        check("rs_addr", 32'(wa[b]), 32'd0);
        check("rs_data", 32'(wd[b]), 32'h22);

        // parity error then good byte
        do_reset();
        pulse_start();
        b = wn;
        send_frame(8'h5A, 1'b1, 1'b1);
        check("pe_err", 32'(err_cnt), 32'd1);
        check("pe_nwr", 32'(wn - b), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("pe_nwr2", 32'(wn - b), 32'd1);
        check("pe_addr", 32'(wa[b]), 32'd0);
        check("pe_data", 32'(wd[b]), 32'h5A);
        check("pe_err2", 32'(err_cnt), 32'd1);

        // framing error then short glitch
        do_reset();
        pulse_start();
        b = wn;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        cyc(2);
        rx = 1'b1;
        cyc(3 * BIT_CYC);
        check("fe_err", 32'(err_cnt), 32'd1);
        check("fe_nwr", 32'(wn - b), 32'd0);
        send_good(8'hA5);
        check("fe_nwr2", 32'(wn - b), 32'd1);
        check("fe_addr", 32'(wa[b]), 32'd0);
        check("fe_data", 32'(wd[b]), 32'hA5);
        check("fe_err2", 32'(err_cnt), 32'd1);

        // reset during data bit 4
        do_reset();
        pulse_start();
        send_good(8'h01);
        send_good(8'h02);
        check("mr_pre", 32'(bram_addr), 32'd2);
        b = wn;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b0;
        cyc(3);
        rst_n = 1'b0;
        #1;
        check("mr_we", 32'(bram_we), 32'd0);
        check("mr_addr", 32'(bram_addr), 32'd0);
        check("mr_din", 32'(bram_din), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_led", 32'(led), 32'hC0);
        rx = 1'b1;
        cyc(12 * BIT_CYC);
        check("mr_nwr", 32'(wn - b), 32'd0);
        rst_n = 1'b1;
        cyc(3);
        pulse_start();
        send_good(8'h77);
        check("mr_nwr2", 32'(wn - b), 32'd1);
        check("mr_addr2", 32'(wa[b]), 32'd0);
        check("mr_data2", 32'(wd[b]), 32'h77);

        // start in RECV has no effect
        do_reset();
        pulse_start();
        b = wn;
        send_good(8'h40);
        send_good(8'h41);
        send_good(8'h42);
        pulse_start();
        check("sr_addr", 32'(bram_addr), 32'd3);
        send_good(8'h43);
        check("sr_nwr", 32'(wn - b), 32'd4);
        check("sr_addr3", 32'(wa[b+3]), 32'd3);
        check("sr_data3", 32'(wd[b+3]), 32'h43);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
